rgb_byte_pack: RTL and testbench
================================

# rgb_byte_pack

Upstream pixel assembler between the UART receive stream and `rgb2gray`. Collects three consecutive bytes (R, G, B order) from a byte-wide ready/valid stream into one registered 24-bit pixel, marks the last pixel of each line, and optionally recovers byte alignment after an inter-byte stall. It replaces ad-hoc byte packing in the top level with a buffered, back-pressure-correct stage.

## Interface
- `linewidth_px_p`, 480, pixels per line; sets the `last_o` position. Must be ≥ 1.
- `timeout_cycles_p`, 100000, idle cycles mid-pixel before a partial pixel is discarded. Used only with the timeout feature; must be ≥ 2.
- `clk_i` input 1: clock; all logic on the rising edge.
- `reset_i` input 1: asynchronous, active-low reset.
- `valid_i` input 1: input byte valid.
- `ready_o` output 1: block accepts a byte this cycle.
- `data_i` input 8: input byte.
- `valid_o` output 1: pixel register holds a valid pixel.
- `ready_i` input 1: downstream accepts the pixel.
- `red_o`, `green_o`, `blue_o` output 8 each: pixel channels.
- `last_o` output 1: the current pixel is column `linewidth_px_p-1`.
- `sync_drop_o` output 1: one-cycle pulse when a partial pixel is discarded.

## Operation
- Byte accept: `valid_i && ready_o`.
- Pixel accept: `valid_o && ready_i`.
- Phase FSM has three states: `PH_R`, `PH_G`, `PH_B`.
  - `PH_R` → `PH_G` on byte accept; the byte is stored in the R holding register.
  - `PH_G` → `PH_B` on byte accept; the byte is stored in the G holding register.
  - `PH_B` → `PH_R` on byte accept; the output register loads {R hold, G hold, `data_i`} and `valid_o` is set.
- `ready_o` is 1 in `PH_R` and `PH_G`, independent of the output register.
  - In `PH_B`, `ready_o` = `!valid_o || ready_i`. This is a combinational path from `ready_i` and is intentional, so a full pixel per three bytes streams without bubbles.
- Output register clear rules:
  - `valid_o` clears on pixel accept unless a new pixel loads in the same cycle.
  - If a pixel is accepted and a new pixel loads in the same cycle, the new pixel is loaded and `valid_o` stays 1.
  - Outputs are stable while `valid_o && !ready_i`.
- Column counter: width `$clog2(linewidth_px_p)`, minimum 1 bit.
  - Increments on each pixel load and wraps to 0 after `linewidth_px_p-1`.
  - `last_o` is registered with the pixel and equals (counter == `linewidth_px_p-1`) at load.
  - With `linewidth_px_p` = 1, every pixel has `last_o` = 1.
- Reset (`reset_i` low, asynchronous):
  - FSM goes to `PH_R`; holding registers, column counter and timeout counter clear.
  - `valid_o`, `red_o`, `green_o`, `blue_o`, `last_o` and `sync_drop_o` are 0.
  - `ready_o` is 1 (phase `PH_R`).
  - Reset mid-pixel discards partial bytes without a `sync_drop_o` pulse.
  - Deassertion takes effect from the next rising edge.

## Timing
- Latency: the third (B) byte accepted on edge t gives `valid_o` = 1 after edge t, i.e. visible in cycle t+1.
- Throughput: one pixel per three accepted bytes; no idle cycles inserted.
- `sync_drop_o` is registered and asserts in the cycle after the timeout fires, for exactly one cycle.
- Timeout never blocks `ready_o`.

## Configuration
- `RGB_PACK_TIMEOUT_EN` defined:
  - An idle counter runs while in `PH_G` or `PH_B` with no byte accept. It clears on any byte accept and while in `PH_R`.
  - When the counter reaches `timeout_cycles_p-1` with no accept that cycle, the FSM returns to `PH_R`, the holding registers are discarded, `sync_drop_o` pulses, and the column counter is unaffected.
  - A byte accept in the same cycle as the timeout wins: normal advance, no drop.
- `RGB_PACK_TIMEOUT_EN` undefined:
  - No idle counter; `sync_drop_o` is tied to 0 and `timeout_cycles_p` is ignored.
  - Alignment is lost only through reset.

## Test plan
- Stream bytes 0x11,0x22,0x33 with `ready_i`=1 -> `red_o`=0x11, `green_o`=0x22, `blue_o`=0x33, `valid_o`=1 in the cycle after the B accept, `last_o`=0.
- Hold `ready_i`=0 and send 6 bytes -> first pixel is held stable; `ready_o`=0 in `PH_B` for the second pixel until `ready_i` rises; both pixels are delivered in order with no loss.
- `linewidth_px_p`=4, send 9 pixels -> `last_o`=1 on pixels 4 and 8 only; counter wraps.
- Timeout enabled, `timeout_cycles_p`=16: send 0xAA, idle 20 cycles, then send 0x01,0x02,0x03 -> one `sync_drop_o` pulse; next pixel is (0x01,0x02,0x03).
- Timeout enabled: a byte arrives exactly on the timeout cycle -> no `sync_drop_o` and the phase advances normally.
- Assert `reset_i` low asynchronously mid-pixel (after the G byte) -> `valid_o`=0 and `ready_o`=1 immediately; the next three bytes form a clean pixel.

Source files
------------

// File: rtl/rgb_byte_pack_if.sv
// Byte-in / pixel-out stream bundle for rgb_byte_pack.
// The slave modport is the packer's view; the master modport is the environment's view.
interface rgb_byte_pack_if;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] red_o;
  logic [7:0] green_o;
  logic [7:0] blue_o;
  logic       last_o;
  logic       sync_drop_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, red_o, green_o, blue_o, last_o, sync_drop_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, red_o, green_o, blue_o, last_o, sync_drop_o
  );
endinterface

// File: rtl/rgb_byte_pack.sv
// Packs R,G,B bytes from a ready/valid byte stream into one registered pixel with end-of-line flag.
// Optional mid-pixel idle timeout that realigns to R is enabled by defining RGB_PACK_TIMEOUT_EN.
module rgb_byte_pack #(
  parameter int linewidth_px_p   = 480,
  parameter int timeout_cycles_p = 100000
) (
  input  logic            clk_i,
  input  logic            reset_i,
  rgb_byte_pack_if.slave  bus
);

  typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_B = 2'd2} phase_e;

  localparam int              COL_W    = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(linewidth_px_p - 1);

  if (linewidth_px_p < 1 || timeout_cycles_p < 2) begin : g_param_check
    $error("rgb_byte_pack: linewidth_px_p must be >= 1 and timeout_cycles_p >= 2");
  end

  phase_e           r_phase;
  logic [7:0]       r_hold_r;
  logic [7:0]       r_hold_g;
  logic             r_valid;
  logic [7:0]       r_red;
  logic [7:0]       r_green;
  logic [7:0]       r_blue;
  logic             r_last;
  logic [COL_W-1:0] r_col;

  logic w_ready;
  logic w_byte_acc;
  logic w_pix_acc;

  // The B byte may only enter when the pixel register is free or draining this
  // cycle; the ready_i feed-through keeps a pixel every three bytes bubble-free.
  assign w_ready    = (r_phase != PH_B) || !r_valid || bus.ready_i;
  assign w_byte_acc = bus.valid_i && w_ready;
  assign w_pix_acc  = r_valid && bus.ready_i;

`ifdef RGB_PACK_TIMEOUT_EN
  localparam int              IDLE_W    = $clog2(timeout_cycles_p);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(timeout_cycles_p - 1);

  logic [IDLE_W-1:0] r_idle;
  logic              r_sync_drop;
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_phase     <= PH_R;
      r_hold_r    <= '0;
      r_hold_g    <= '0;
      r_valid     <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_last      <= 1'b0;
      r_col       <= '0;
`ifdef RGB_PACK_TIMEOUT_EN
      r_idle      <= '0;
      r_sync_drop <= 1'b0;
`endif
    end else begin
`ifdef RGB_PACK_TIMEOUT_EN
      r_sync_drop <= 1'b0;
`endif
      // NOTE: non-blocking assignments let a later assignment in this block
      // override an earlier one, so a load below wins over the drain clear here.
      if (w_pix_acc) r_valid <= 1'b0;

      if (w_byte_acc) begin
        case (r_phase)
          PH_R: begin
            r_hold_r <= bus.data_i;
            r_phase  <= PH_G;
          end
          PH_G: begin
            r_hold_g <= bus.data_i;
            r_phase  <= PH_B;
          end
          PH_B: begin
            r_red   <= r_hold_r;
            r_green <= r_hold_g;
            r_blue  <= bus.data_i;
            r_valid <= 1'b1;
            r_last  <= (r_col == COL_LAST);
            r_col   <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
            r_phase <= PH_R;
          end
          default: r_phase <= PH_R;
        endcase
      end

`ifdef RGB_PACK_TIMEOUT_EN
      // An accept on the expiry cycle takes the branch above and skips the drop.
      if (w_byte_acc || r_phase == PH_R) begin
        r_idle <= '0;
      end else if (r_idle == IDLE_LAST) begin
        r_idle      <= '0;
        r_phase     <= PH_R;
        r_hold_r    <= '0;
        r_hold_g    <= '0;
        r_sync_drop <= 1'b1;
      end else begin
        r_idle <= r_idle + IDLE_W'(1);
      end
`endif
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_valid;
  assign bus.red_o   = r_red;
  assign bus.green_o = r_green;
  assign bus.blue_o  = r_blue;
  assign bus.last_o  = r_last;
`ifdef RGB_PACK_TIMEOUT_EN
  assign bus.sync_drop_o = r_sync_drop;
`else
  assign bus.sync_drop_o = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_byte_pack.sv
// Self-checking bench for rgb_byte_pack: directed vector table, hand-written corner sequences,
// and a randomized run scored against a queue-based pixel model (timeout cases under RGB_PACK_TIMEOUT_EN).
module tb_rgb_byte_pack;

  localparam int LW = 4;
  localparam int TO = 16;

  logic clk;
  logic rst_n;

  rgb_byte_pack_if bus ();

  rgb_byte_pack #(
    .linewidth_px_p   (LW),
    .timeout_cycles_p (TO)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: byte list -> pixel queue ----------------
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       last;
  } pix_t;

  pix_t       exp_q[$];
  logic [7:0] part_q[$];
  int         col_m        = 0;
  int         idle_m       = 0;
  bit         drop_pending = 1'b0;
  bit         prev_hold    = 1'b0;
  logic [24:0] prev_out;
  pix_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      part_q.delete();
      col_m        = 0;
      idle_m       = 0;
      drop_pending = 1'b0;
      prev_hold    = 1'b0;
    end else begin
      check("sb_sync_drop", 32'(bus.sync_drop_o), 32'(drop_pending));
      drop_pending = 1'b0;
      check("sb_valid", 32'(bus.valid_o), 32'(exp_q.size() != 0));
      check("sb_ready", 32'(bus.ready_o),
            32'((part_q.size() < 2) || (exp_q.size() == 0) || bus.ready_i));
      if (prev_hold)
        check("sb_stable", 32'({bus.red_o, bus.green_o, bus.blue_o, bus.last_o}), 32'(prev_out));

      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pixel", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_rgb", 32'({bus.red_o, bus.green_o, bus.blue_o}), 32'({e.r, e.g, e.b}));
          check("sb_last", 32'(bus.last_o), 32'(e.last));
        end
      end

      if (bus.valid_i && bus.ready_o) begin
        part_q.push_back(bus.data_i);
        idle_m = 0;
        if (part_q.size() == 3) begin
          exp_q.push_back('{r: part_q[0], g: part_q[1], b: part_q[2], last: (col_m == LW - 1)});
          col_m = (col_m + 1) % LW;
          part_q.delete();
        end
      end else if (part_q.size() != 0) begin
`ifdef RGB_PACK_TIMEOUT_EN
        idle_m++;
        if (idle_m == TO) begin
          part_q.delete();
          idle_m       = 0;
          drop_pending = 1'b1;
        end
`endif
      end

      prev_hold = bus.valid_o && !bus.ready_i;
      prev_out  = {bus.red_o, bus.green_o, bus.blue_o, bus.last_o};
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.valid_i = 1'b1;
    bus.data_i  = b;
    @(negedge clk);
    while (!bus.ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.ready_o) check("byte_accept_wait", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic expect_pixel(input string name, input logic [23:0] rgb, input logic last);
    @(negedge clk);
    check({name, "_valid"}, 32'(bus.valid_o), 32'(1));
    check({name, "_rgb"}, 32'({bus.red_o, bus.green_o, bus.blue_o}), 32'(rgb));
    check({name, "_last"}, 32'(bus.last_o), 32'(last));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       exp_last;
  } vec_t;

  vec_t vecs[9];
  int   drops;
  bit   acc;
  int   gap;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h11, 8'h22, 8'h33, 1'b0};
    for (int i = 1; i < 9; i++)
      vecs[i] = '{8'(8'h40 + i), 8'(8'h80 + i), 8'(8'hC0 + i), ((i % LW) == LW - 1)};

    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b1;
    rst_n       = 1'b0;

    // reset state
    #12;
    check("rst_valid", 32'(bus.valid_o), 32'(0));
    check("rst_ready", 32'(bus.ready_o), 32'(1));
    check("rst_rgb", 32'({bus.red_o, bus.green_o, bus.blue_o}), 32'(0));
    check("rst_last", 32'(bus.last_o), 32'(0));
    check("rst_sync_drop", 32'(bus.sync_drop_o), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // vector table: nine pixels, last on the 4th and 8th
    for (int i = 0; i < 9; i++) begin
      send_byte(vecs[i].r);
      send_byte(vecs[i].g);
      send_byte(vecs[i].b);
      expect_pixel("vec", {vecs[i].r, vecs[i].g, vecs[i].b}, vecs[i].exp_last);
    end

    // back-pressure: second pixel's B byte waits for ready_i
    bus.ready_i = 1'b0;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    send_byte(8'hB1); send_byte(8'hB2);
    bus.valid_i = 1'b1;
    bus.data_i  = 8'hB3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", 32'(bus.ready_o), 32'(0));
      check("bp_hold_rgb", 32'({bus.red_o, bus.green_o, bus.blue_o}), 32'(24'hA1A2A3));
      @(posedge clk);
      #1;
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("bp_ready_comb", 32'(bus.ready_o), 32'(1));
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    expect_pixel("bp_second", 24'hB1B2B3, 1'b0);

    // mid-pixel stall
    send_byte(8'hAA);
    drops = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.sync_drop_o) drops++;
      @(posedge clk);
      #1;
    end
`ifdef RGB_PACK_TIMEOUT_EN
    check("to_drop_count", 32'(drops), 32'(1));
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    expect_pixel("to_realign", 24'h010203, 1'b1);

    // byte arrives on the expiry cycle: accept wins, no drop
    send_byte(8'hC1);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'hC2);
    @(negedge clk);
    check("to_edge_no_drop", 32'(bus.sync_drop_o), 32'(0));
    @(posedge clk);
    #1;
    send_byte(8'hC3);
    expect_pixel("to_edge_pixel", 24'hC1C2C3, 1'b0);
`else
    check("nto_drop_count", 32'(drops), 32'(0));
    send_byte(8'h01); send_byte(8'h02);
    expect_pixel("nto_keep", 24'hAA0102, 1'b1);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    expect_pixel("nto_next", 24'h030405, 1'b0);
`endif

    // asynchronous reset after the G byte, with a pixel pending
    bus.ready_i = 1'b0;
    send_byte(8'h5A); send_byte(8'h5B); send_byte(8'h5C);
    send_byte(8'h61); send_byte(8'h62);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.valid_o), 32'(0));
    check("arst_ready", 32'(bus.ready_o), 32'(1));
    check("arst_rgb", 32'({bus.red_o, bus.green_o, bus.blue_o}), 32'(0));
    check("arst_sync_drop", 32'(bus.sync_drop_o), 32'(0));
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.ready_i = 1'b1;
    send_byte(8'h71); send_byte(8'h72); send_byte(8'h73);
    expect_pixel("arst_clean", 24'h717273, 1'b0);

    // randomized traffic against the model
    gap = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = bus.valid_i && bus.ready_o;
      @(posedge clk);
      #1;
      if (!bus.valid_i || acc) begin
        if (gap > 0) begin
          gap--;
          bus.valid_i = 1'b0;
        end else begin
          bus.valid_i = ($urandom_range(0, 9) < 7);
          bus.data_i  = 8'($urandom);
          if ($urandom_range(0, 149) == 0) gap = TO + $urandom_range(-2, 3);
        end
      end
      bus.ready_i = ($urandom_range(0, 9) < 6);
    end

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_valid", 32'(bus.valid_o), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
